reg_piso_tx: RTL
================

REG_PISO_TX -- requirements
Module: reg_piso_tx

Interface
REQ-001 SHALL have parameter: n, 8, data word width in bits (legal n >= 2).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled only on rising clock.
REQ-004 SHALL have port: ena  input  1  load request; word on R offered for capture.
REQ-005 SHALL have port: R  input  n  parallel word to transmit.
REQ-006 SHALL have port: ready  output  1  high when a load request will be accepted.
REQ-007 SHALL have port: sout  output  1  serial data bit, LSB first.
REQ-008 SHALL have port: sout_valid  output  1  sout carries a valid bit.
REQ-009 SHALL have port: sready  input  1  downstream accepts sout this cycle.
REQ-010 SHALL have port: busy  output  1  high from load until done pulse completes.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after last bit accepted.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-013 IDLE: ready=1, busy=0, sout_valid=0, sout=0, done=0.
REQ-014 IDLE with ena=1: capture R into shift register, clear bit counter, enter SHIFT next cycle; ena=0 stays IDLE.
REQ-015 SHIFT: ready=0, busy=1, sout_valid=1, sout=shift register bit 0.
REQ-016 Bit transfer SHALL occur only on a cycle with sout_valid=1 and sready=1; then shift right one place and increment counter.
REQ-017 sready=0 SHALL hold sout, sout_valid, counter and shift register unchanged (no bit loss, no duplication).
REQ-018 Transfer of the final bit SHALL move SHIFT->DONE; DONE lasts exactly one cycle with done=1, busy=1, sout_valid=0, then IDLE.
REQ-019 ena while ready=0 SHALL be ignored; R changes after capture SHALL not affect the word in flight.
REQ-020 Counter SHALL be ceil(log2(n+1)) bits wide and never wrap within a word.
REQ-021 Minimum latency with sready held high: load edge k, bit i on sout during cycle k+1+i, done in cycle k+n+1, ready in cycle k+n+2.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, clear shift register and counter, and drive ready=1, busy=0, sout=0, sout_valid=0, done=0 from that edge.
REQ-023 Reset mid-word SHALL abort the transfer without a done pulse; reset SHALL take priority over ena and sready.
REQ-024 Without reset the block SHALL not rely on power-up state for correct operation after first reset.

Configuration
REQ-025 Macro REG_PISO_TX_PARITY_EN SHALL control parity: defined -> an even-parity bit of the captured word (computed at load) is sent as bit n+1 after the data bits, under the same handshake, and DONE follows its transfer; undefined -> exactly n bits sent, no parity logic present.

Verification
REQ-026 n=8, no parity, sready=1, load R=8'hA5 -> sout 1,0,1,0,0,1,0,1 over cycles 1-8, done=1 cycle 9, ready=1 cycle 10.
REQ-027 Parity enabled, load 8'h07 then 8'hA5 -> ninth bit 1 then 0; done after the ninth accepted bit each word.
REQ-028 Load 8'h3C, sready=0 for cycles 3-5 -> sout held at bit 2 value (1) with sout_valid=1; full word 0,0,1,1,1,1,0,0 delivered, done delayed by 3 cycles.
REQ-029 ena=1 with R=8'hFF during SHIFT of 8'h00 -> all eight bits 0, ready stays 0 until IDLE, 8'hFF never transmitted.
REQ-030 reset=1 in cycle 4 of a word -> next edge ready=1, sout_valid=0, busy=0, no done pulse; subsequent load of 8'h81 sends 1,0,0,0,0,0,0,1 correctly.

Source files
------------

// File: rtl/reg_piso_tx.sv
// reg_piso_tx -- parallel-in / serial-out transmitter with valid/ready output handshake.
//
// A word presented on R with ena=1 while the block is idle is captured. It is then
// sent LSB first on sout, one bit per accepted transfer. A transfer is a cycle with
// sout_valid=1 and sready=1. After the last bit is accepted, done pulses for one
// cycle. The block then returns to idle.
//
// Optional feature (compile-time macro REG_PISO_TX_PARITY_EN):
//   defined   -> an even-parity bit of the captured word follows the n data bits.
//   undefined -> exactly n data bits are sent and no parity logic exists.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   ena         in   load request (honoured only while ready=1)
//   R[n-1:0]    in   parallel word to transmit
//   ready       out  block will accept a load request this cycle
//   sout        out  serial data bit (LSB first)
//   sout_valid  out  sout carries a valid bit
//   sready      in   downstream accepts sout this cycle
//   busy        out  high from load until the done pulse completes
//   done        out  one-cycle pulse after the final bit is accepted
//
// All outputs come straight from flops. Their next values are derived from the
// next FSM state and the next shift-register contents.
module reg_piso_tx #(
    parameter int n = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ena,
    input  logic [n-1:0] R,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sready,
    output logic         busy,
    output logic         done
);

`ifdef REG_PISO_TX_PARITY_EN
    localparam int NB = n + 1;
`else
    localparam int NB = n;
`endif
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            sout_q, sout_d;
    logic            sout_valid_q, sout_valid_d;
    logic            done_q, done_d;
    logic [NB-1:0]   load_word;

    // The parity bit sits above the data so that it is shifted out after bit n-1.
    // XOR-reducing the word yields 1 when the data has an odd number of ones,
    // which makes the total count of ones even.
`ifdef REG_PISO_TX_PARITY_EN
    assign load_word = {^R, R};
`else
    assign load_word = R;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (ena) begin
                    shreg_d = load_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // sout_valid is always 1 in SHIFT, so sready alone qualifies a transfer.
                if (sready) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The outputs are registered. They are therefore decoded from the state
        // the block is about to enter.
        ready_d      = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        sout_valid_d = (state_d == SHIFT);
        sout_d       = (state_d == SHIFT) && shreg_d[0];
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule
